// File: rtl/task1_sbox_init.sv
// rtl/task1_sbox_init.sv - ARC4 stage 1: fills the 256x8 state RAM with S[i] = i after reset

// Single-port 256x8 RAM with a synchronous write and a registered read.
// RAM contents are never reset.
module task1_sbox_ram (
    input  logic       clock,
    input  logic [7:0] address,
    input  logic [7:0] data,
    input  logic       wren,
    output logic [7:0] q
);

    logic [7:0] mem_data [0:255];

    // Write port plus registered read of the addressed word
    always_ff @(posedge clock) begin
        if (wren) begin
            mem_data[address] <= data;
        end
        q <= mem_data[address];
    end

endmodule

module task1_sbox_init (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic       w_rst_n;
    logic [1:0] r_state;
    logic [7:0] r_i;
    logic       w_wren;
    logic [7:0] w_address;
    logic [7:0] w_data;
    logic [7:0] w_q;
    logic       w_done;
    logic       w_unused;

    // KEY[3] is the asynchronous active-low reset; the other keys and switches do nothing here
    assign w_rst_n  = KEY[3];
    assign w_unused = ^{SW, KEY[2:0], w_q};

    // Sequencer: one idle cycle in START, then one write per cycle until i == 255 has been written
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_START;
            r_i     <= 8'd0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_i     <= 8'd0;
                    r_state <= ST_FILL;
                end
                ST_FILL: begin
                    r_i <= r_i + 8'd1;
                    // Exit on the last index, not on the counter wrapping back to zero
                    if (r_i == 8'hFF) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_START;
                    r_i     <= 8'd0;
                end
            endcase
        end
    end

    // Write strobe decoded straight from state so a reset drops it immediately;
    // address and data are parked at zero whenever no write is in progress
    assign w_wren    = (r_state == ST_FILL);
    assign w_address = w_wren ? r_i : 8'd0;
    assign w_data    = w_wren ? r_i : 8'd0;
    assign w_done    = (r_state == ST_DONE);

    task1_sbox_ram s (
        .clock   (CLOCK_50),
        .address (w_address),
        .data    (w_data),
        .wren    (w_wren),
        .q       (w_q)
    );

    // Displays are blanked (active-low) and only LEDR[0] carries status
    assign HEX0 = 7'b1111111;
    assign HEX1 = 7'b1111111;
    assign HEX2 = 7'b1111111;
    assign HEX3 = 7'b1111111;
    assign HEX4 = 7'b1111111;
    assign HEX5 = 7'b1111111;
    assign LEDR = {9'd0, w_done};

endmodule

// File: tb/tb_task1_sbox_init.sv
// tb/tb_task1_sbox_init.sv - table-driven and randomized checks of the S-box fill wrapper

module tb_task1_sbox_init;

    logic       CLOCK_50;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int checks = 0;
    int errors = 0;

    int cyc;
    int wr_count;
    int first_cyc;
    int last_cyc;
    bit toggle_en;

    task1_sbox_init dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Bus monitor: the k-th write after reset release must carry address k and data k,
    // the done flag rises after 257 clock edges, displays stay blank
    always @(negedge CLOCK_50) begin
        chk("hex_blank", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {42{1'b1}});
        chk("ledr_hi", 64'(LEDR[9:1]), 64'd0);
        if (!KEY[3]) begin
            cyc       = 0;
            wr_count  = 0;
            first_cyc = -1;
            last_cyc  = -1;
            chk("wren_in_reset", 64'(dut.s.wren), 64'd0);
            chk("done_in_reset", 64'(LEDR[0]), 64'd0);
        end else begin
            if (cyc < 100000) cyc++;
            chk("done_flag", 64'(LEDR[0]), 64'(cyc >= 257));
            if (dut.s.wren) begin
                chk("wr_addr", 64'(dut.s.address), 64'(wr_count));
                chk("wr_data", 64'(dut.s.data), 64'(wr_count));
                if (wr_count == 0) first_cyc = cyc;
                last_cyc = cyc;
                wr_count++;
            end else begin
                chk("idle_bus", 64'({dut.s.address, dut.s.data}), 64'd0);
            end
        end
    end

    // Optional noise on the ignored inputs
    always @(posedge CLOCK_50) begin
        if (toggle_en) begin
            #3;
            SW       = 10'($urandom);
            KEY[2:0] = 3'($urandom);
        end
    end

    typedef struct {
        bit         pre;
        logic [7:0] pat;
        bit         tog;
        int         abort_n;
        int         exp_partial;
        bit         exp_done;
    } vec_t;

    vec_t tbl [6];

    function automatic int model_partial(input int n);
        if (n <= 1) return 0;
        if (n >= 257) return 256;
        return n - 1;
    endfunction

    task automatic check_mem(input string name, input int partial, input logic [7:0] pat);
        logic [7:0] exp;
        for (int j = 0; j < 256; j++) begin
            exp = (j < partial) ? 8'(j) : pat;
            chk(name, 64'(dut.s.mem_data[j]), 64'(exp));
        end
    endtask

    task automatic run_case(input vec_t v);
        @(negedge CLOCK_50);
        #1;
        KEY = 4'b0000;
        SW  = 10'd0;
        if (v.pre) begin
            for (int j = 0; j < 256; j++) dut.s.mem_data[j] = v.pat;
        end
        repeat (2) @(negedge CLOCK_50);
        #1;
        chk("rst_ledr", 64'(LEDR), 64'd0);
        toggle_en = v.tog;
        KEY[3] = 1'b1;
        if (v.abort_n >= 0) begin
            repeat (v.abort_n) @(negedge CLOCK_50);
            chk("done_before_abort", 64'(LEDR[0]), 64'(v.exp_done));
            #1;
            KEY[3] = 1'b0;
            #1;
            chk("abort_ledr", 64'(LEDR), 64'd0);
            chk("abort_wren", 64'(dut.s.wren), 64'd0);
            if (v.pre) check_mem("partial_mem", v.exp_partial, v.pat);
            repeat (3) @(negedge CLOCK_50);
            #1;
            KEY[3] = 1'b1;
        end
        repeat (265) @(negedge CLOCK_50);
        #1;
        chk("wr_count", 64'(wr_count), 64'd256);
        chk("first_wr_cyc", 64'(first_cyc), 64'd1);
        chk("last_wr_cyc", 64'(last_cyc), 64'd256);
        chk("final_ledr", 64'(LEDR), 64'd1);
        check_mem("final_mem", 256, 8'h00);
        toggle_en = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   n;
        KEY       = 4'b0000;
        SW        = 10'd0;
        toggle_en = 1'b0;

        tbl[0] = '{pre: 1'b0, pat: 8'h00, tog: 1'b0, abort_n: -1,  exp_partial: 256, exp_done: 1'b1};
        tbl[1] = '{pre: 1'b1, pat: 8'hFF, tog: 1'b0, abort_n: -1,  exp_partial: 256, exp_done: 1'b1};
        tbl[2] = '{pre: 1'b1, pat: 8'h5A, tog: 1'b1, abort_n: -1,  exp_partial: 256, exp_done: 1'b1};
        tbl[3] = '{pre: 1'b1, pat: 8'hFF, tog: 1'b0, abort_n: 101, exp_partial: 100, exp_done: 1'b0};
        tbl[4] = '{pre: 1'b1, pat: 8'hA5, tog: 1'b1, abort_n: 1,   exp_partial: 0,   exp_done: 1'b0};
        tbl[5] = '{pre: 1'b1, pat: 8'h3C, tog: 1'b0, abort_n: 300, exp_partial: 256, exp_done: 1'b1};

        repeat (2) @(negedge CLOCK_50);
        chk("init_ledr", 64'(LEDR), 64'd0);
        chk("init_wren", 64'(dut.s.wren), 64'd0);

        for (int k = 0; k < 6; k++) begin
            run_case(tbl[k]);
        end

        for (int k = 0; k < 6; k++) begin
            n             = int'($urandom_range(0, 262));
            v.pre         = 1'b1;
            v.pat         = 8'($urandom);
            v.tog         = 1'($urandom);
            v.abort_n     = n;
            v.exp_partial = model_partial(n);
            v.exp_done    = (n >= 257);
            run_case(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
